// File: rtl/dbus_uart_tx.sv
// Memory-mapped 8N1 UART transmitter on the TinuC data bus: TX FIFO, serializer, status/baud/ctrl registers.
// Optional parity bit between data and stop is built when UART_PARITY_EN is defined.
module dbus_uart_tx #(
    parameter logic [9:0]  BASE_ADDR   = 10'h3FC,
    parameter int          FIFO_DEPTH  = 8,
    parameter logic [15:0] DEFAULT_DIV = 16'd434
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic [9:0]  daddr,
    input  logic [31:0] ddata_w,
    input  logic        d_rw,
    output logic [31:0] ddata_r,
    output logic        txd,
    output logic        irq
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    // ------------------------------------------------------------------
    // Bus decode
    // ------------------------------------------------------------------
    logic       sel;
    logic [1:0] idx;
    logic       wr_en;
    logic       rd_en;
    logic       push_req;
    logic       unused_ddata;

    assign sel          = (daddr[9:2] == BASE_ADDR[9:2]);
    assign idx          = daddr[1:0];
    assign wr_en        = sel & d_rw;
    assign rd_en        = sel & ~d_rw;
    assign push_req     = wr_en & (idx == 2'd0);
    assign unused_ddata = ^ddata_w[31:16];

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [7:0]       fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             ovf_q, ovf_d;
    logic [15:0]      div_q, div_d;
    logic             enable_q, enable_d;
    logic             irq_en_q, irq_en_d;
    logic             ctrl_odd;

    state_t           state_q, state_d;
    logic [15:0]      baud_cnt_q, baud_cnt_d;
    logic [2:0]       bit_cnt_q, bit_cnt_d;
    logic [7:0]       shift_q, shift_d;
    logic [15:0]      act_div_q, act_div_d;
    logic             txd_q, txd_d;
    logic [31:0]      ddata_r_q, ddata_r_d;

`ifdef UART_PARITY_EN
    logic             odd_q, odd_d;
    logic             parity_q, parity_d;
    assign ctrl_odd = odd_q;
`else
    assign ctrl_odd = 1'b0;
`endif

    logic        fifo_empty;
    logic        fifo_full;
    logic        push_ok;
    logic        pop;
    logic        busy;
    logic        can_start;
    logic [7:0]  fifo_head;
    logic [15:0] load_cnt;
    logic [15:0] reload_cnt;
    logic        baud_tick;

    assign fifo_empty = (count_q == '0);
    assign fifo_full  = (count_q == CNT_W'(FIFO_DEPTH));
    assign fifo_head  = fifo_mem[rd_ptr_q];
    assign busy       = (state_q != S_IDLE);
    assign can_start  = enable_q & ~fifo_empty;
    assign baud_tick  = (baud_cnt_q == 16'd0);
    // A zero divisor behaves as one cycle per bit: the countdown reloads to 0.
    assign load_cnt   = (div_q == 16'd0) ? 16'd0 : div_q - 16'd1;
    assign reload_cnt = (act_div_q == 16'd0) ? 16'd0 : act_div_q - 16'd1;

    // A push into a full FIFO still lands if the serializer pops in the same cycle.
    assign push_ok = push_req & (~fifo_full | pop);

    // ------------------------------------------------------------------
    // Serializer FSM
    // ------------------------------------------------------------------
    always_comb begin
        state_d    = state_q;
        baud_cnt_d = baud_cnt_q;
        bit_cnt_d  = bit_cnt_q;
        shift_d    = shift_q;
        act_div_d  = act_div_q;
        pop        = 1'b0;
        txd_d      = 1'b1;
`ifdef UART_PARITY_EN
        parity_d   = parity_q;
`endif
        case (state_q)
            S_IDLE: begin
                txd_d = 1'b1;
                if (can_start) begin
                    pop        = 1'b1;
                    shift_d    = fifo_head;
                    act_div_d  = div_q;
                    baud_cnt_d = load_cnt;
                    bit_cnt_d  = 3'd0;
                    state_d    = S_START;
`ifdef UART_PARITY_EN
                    parity_d   = (^fifo_head) ^ ctrl_odd;
`endif
                end
            end
            S_START: begin
                txd_d = 1'b0;
                if (baud_tick) begin
                    baud_cnt_d = reload_cnt;
                    bit_cnt_d  = 3'd0;
                    state_d    = S_DATA;
                end else begin
                    baud_cnt_d = baud_cnt_q - 16'd1;
                end
            end
            S_DATA: begin
                txd_d = shift_q[0];
                if (baud_tick) begin
                    baud_cnt_d = reload_cnt;
                    shift_d    = {1'b0, shift_q[7:1]};
                    if (bit_cnt_q == 3'd7) begin
`ifdef UART_PARITY_EN
                        state_d = S_PARITY;
`else
                        state_d = S_STOP;
`endif
                    end else begin
                        bit_cnt_d = bit_cnt_q + 3'd1;
                    end
                end else begin
                    baud_cnt_d = baud_cnt_q - 16'd1;
                end
            end
            S_PARITY: begin
`ifdef UART_PARITY_EN
                txd_d = parity_q;
`else
                txd_d = 1'b1;
`endif
                if (baud_tick) begin
                    baud_cnt_d = reload_cnt;
                    state_d    = S_STOP;
                end else begin
                    baud_cnt_d = baud_cnt_q - 16'd1;
                end
            end
            S_STOP: begin
                txd_d = 1'b1;
                if (baud_tick) begin
                    // Chain straight into the next frame so there is no idle gap.
                    if (can_start) begin
                        pop        = 1'b1;
                        shift_d    = fifo_head;
                        act_div_d  = div_q;
                        baud_cnt_d = load_cnt;
                        bit_cnt_d  = 3'd0;
                        state_d    = S_START;
`ifdef UART_PARITY_EN
                        parity_d   = (^fifo_head) ^ ctrl_odd;
`endif
                    end else begin
                        state_d = S_IDLE;
                    end
                end else begin
                    baud_cnt_d = baud_cnt_q - 16'd1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // FIFO pointers, registers, read mux
    // ------------------------------------------------------------------
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_ok) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        count_d = count_q + CNT_W'(push_ok) - CNT_W'(pop);
    end

    always_comb begin
        ovf_d    = ovf_q;
        div_d    = div_q;
        enable_d = enable_q;
        irq_en_d = irq_en_q;
`ifdef UART_PARITY_EN
        odd_d    = odd_q;
`endif
        if (wr_en) begin
            case (idx)
                2'd1: if (ddata_w[7]) ovf_d = 1'b0;
                2'd2: div_d = ddata_w[15:0];
                2'd3: begin
                    enable_d = ddata_w[0];
                    irq_en_d = ddata_w[1];
`ifdef UART_PARITY_EN
                    odd_d    = ddata_w[2];
`endif
                end
                default: ;
            endcase
        end
        if (push_req & fifo_full & ~pop) begin
            ovf_d = 1'b1;
        end
    end

    logic [31:0] cnt_ext;
    logic [31:0] status_word;
    logic [31:0] rd_data;

    assign cnt_ext     = 32'(count_q);
    assign status_word = {24'd0, ovf_q, busy, fifo_full, fifo_empty, cnt_ext[3:0]};

    always_comb begin
        rd_data = 32'd0;
        case (idx)
            2'd1:    rd_data = status_word;
            2'd2:    rd_data = {16'd0, div_q};
            2'd3:    rd_data = {29'd0, ctrl_odd, irq_en_q, enable_q};
            default: rd_data = 32'd0;
        endcase
        ddata_r_d = rd_en ? rd_data : 32'd0;
    end

    // ------------------------------------------------------------------
    // Flops
    // ------------------------------------------------------------------
    always_ff @(posedge CLK) begin
        if (push_ok) begin
            fifo_mem[wr_ptr_q] <= ddata_w[7:0];
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            ovf_q      <= 1'b0;
            div_q      <= DEFAULT_DIV;
            enable_q   <= 1'b0;
            irq_en_q   <= 1'b0;
            state_q    <= S_IDLE;
            baud_cnt_q <= 16'd0;
            bit_cnt_q  <= 3'd0;
            shift_q    <= 8'd0;
            act_div_q  <= DEFAULT_DIV;
            txd_q      <= 1'b1;
            ddata_r_q  <= 32'd0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            ovf_q      <= ovf_d;
            div_q      <= div_d;
            enable_q   <= enable_d;
            irq_en_q   <= irq_en_d;
            state_q    <= state_d;
            baud_cnt_q <= baud_cnt_d;
            bit_cnt_q  <= bit_cnt_d;
            shift_q    <= shift_d;
            act_div_q  <= act_div_d;
            txd_q      <= txd_d;
            ddata_r_q  <= ddata_r_d;
        end
    end

`ifdef UART_PARITY_EN
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            odd_q    <= 1'b0;
            parity_q <= 1'b0;
        end else begin
            odd_q    <= odd_d;
            parity_q <= parity_d;
        end
    end
`endif

    assign txd     = txd_q;
    assign ddata_r = ddata_r_q;
    assign irq     = irq_en_q & ((fifo_empty & ~busy) | ovf_q);

endmodule

// File: tb/tb_dbus_uart_tx.sv
// Self-checking bench for dbus_uart_tx: frame-level reference model compared every cycle,
// plus directed literal checks of reset, framing, overflow and back-to-back behaviour.
module tb_dbus_uart_tx;

  localparam logic [9:0] BASE  = 10'h3FC;
  localparam int         DEPTH = 8;
`ifdef UART_PARITY_EN
  localparam int FR_BITS = 11;
`else
  localparam int FR_BITS = 10;
`endif

  logic        CLK = 1'b0;
  logic        RESET;
  logic [9:0]  daddr;
  logic [31:0] ddata_w;
  logic        d_rw;
  logic [31:0] ddata_r;
  logic        txd;
  logic        irq;

  int n_cmp  = 0;
  int n_fail = 0;

  dbus_uart_tx dut (
    .CLK     (CLK),
    .RESET   (RESET),
    .daddr   (daddr),
    .ddata_w (ddata_w),
    .d_rw    (d_rw),
    .ddata_r (ddata_r),
    .txd     (txd),
    .irq     (irq)
  );

  // clock / reset
  always #5 CLK = ~CLK;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
    end
  endtask

  // ------------------------------------------------------------------
  // Behavioural model: FIFO as a queue, each frame as a queue of per-cycle txd levels
  // ------------------------------------------------------------------
  logic [7:0]  m_fifo[$];
  logic        lvl_q[$];
  int          m_left;
  logic [15:0] m_div;
  logic [2:0]  m_ctrl;
  logic        m_ovf;
  logic        exp_txd;
  logic        exp_irq;
  logic [31:0] exp_rd;

  task automatic model_reset();
    m_fifo.delete();
    lvl_q.delete();
    m_left  = 0;
    m_div   = 16'd434;
    m_ctrl  = 3'd0;
    m_ovf   = 1'b0;
    exp_txd = 1'b1;
    exp_irq = 1'b0;
    exp_rd  = 32'd0;
  endtask

  task automatic model_step();
    logic        sel;
    logic [1:0]  idx;
    logic [31:0] rd;
    logic        pop;
    logic        full_pre;
    logic [7:0]  b;
    logic        fr[$];
    int          d;
    sel = (daddr[9:2] == BASE[9:2]);
    idx = daddr[1:0];
    rd  = 32'd0;
    if (sel && !d_rw) begin
      case (idx)
        2'd1: rd = {24'd0, m_ovf, (m_left > 0), (m_fifo.size() == DEPTH),
                    (m_fifo.size() == 0), 4'(m_fifo.size())};
        2'd2: rd = {16'd0, m_div};
        2'd3: rd = {29'd0, m_ctrl};
        default: rd = 32'd0;
      endcase
    end
    if (lvl_q.size() > 0) exp_txd = lvl_q.pop_front();
    else exp_txd = 1'b1;
    if (m_left > 0) m_left--;
    full_pre = (m_fifo.size() == DEPTH);
    pop = (m_left == 0) && m_ctrl[0] && (m_fifo.size() > 0);
    if (pop) begin
      b = m_fifo.pop_front();
      d = (m_div == 16'd0) ? 1 : int'(m_div);
      fr.push_back(1'b0);
      for (int i = 0; i < 8; i++) fr.push_back(b[i]);
`ifdef UART_PARITY_EN
      fr.push_back((^b) ^ m_ctrl[2]);
`endif
      fr.push_back(1'b1);
      foreach (fr[i]) for (int k = 0; k < d; k++) lvl_q.push_back(fr[i]);
      m_left = fr.size() * d;
    end
    if (sel && d_rw) begin
      case (idx)
        2'd0: begin
          if (full_pre && !pop) m_ovf = 1'b1;
          else m_fifo.push_back(ddata_w[7:0]);
        end
        2'd1: if (ddata_w[7]) m_ovf = 1'b0;
        2'd2: m_div = ddata_w[15:0];
        default: begin
          m_ctrl = ddata_w[2:0];
`ifndef UART_PARITY_EN
          m_ctrl[2] = 1'b0;
`endif
        end
      endcase
    end
    exp_rd  = rd;
    exp_irq = m_ctrl[1] & (((m_fifo.size() == 0) && (m_left == 0)) | m_ovf);
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge CLK or posedge RESET);
      if (RESET) model_reset();
      else model_step();
    end
  end

  // scoreboard compare: every cycle, away from the active edge
  initial begin
    forever begin
      @(negedge CLK);
      check("txd", txd, exp_txd);
      check("irq", irq, exp_irq);
      check("ddata_r", ddata_r, exp_rd);
    end
  end

  // ------------------------------------------------------------------
  // Driver tasks (called at a negedge, return at a negedge)
  // ------------------------------------------------------------------
  task automatic bus_idle();
    daddr   = 10'h000;
    d_rw    = 1'b0;
    ddata_w = $urandom;
  endtask

  task automatic bus_write(input logic [1:0] idx, input logic [31:0] data);
    daddr   = {BASE[9:2], idx};
    ddata_w = data;
    d_rw    = 1'b1;
    @(negedge CLK);
    bus_idle();
  endtask

  task automatic bus_read(input logic [1:0] idx, output logic [31:0] data);
    daddr = {BASE[9:2], idx};
    d_rw  = 1'b0;
    @(negedge CLK);
    data = ddata_r;
    bus_idle();
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge CLK);
  endtask

  // ------------------------------------------------------------------
  // Main sequence
  // ------------------------------------------------------------------
  logic [31:0] rdv;
  logic [63:0] got_v, exp_v;
  int          busy_n;
  logic [10:0] fr55;

  initial begin
    RESET = 1'b1;
    bus_idle();
    wait_cycles(3);
    #2 RESET = 1'b0;
    @(negedge CLK);

    // reset values
    check("rst_txd", txd, 1'b1);
    check("rst_irq", irq, 1'b0);
    bus_read(2'd1, rdv); check("rst_status", rdv, 32'h10);
    bus_read(2'd2, rdv); check("rst_bauddiv", rdv, 32'd434);
    bus_read(2'd3, rdv); check("rst_ctrl", rdv, 32'd0);

    // single 0x55 frame at divisor 4
`ifdef UART_PARITY_EN
    fr55 = 11'b10010101010;
`else
    fr55 = 11'b01010101010;
`endif
    bus_write(2'd2, 32'd4);
    bus_write(2'd3, 32'd1);
    bus_write(2'd0, 32'h55);
    daddr  = {BASE[9:2], 2'd1};
    d_rw   = 1'b0;
    got_v  = '0;
    exp_v  = '0;
    busy_n = 0;
    for (int k = 1; k <= 50; k++) begin
      @(negedge CLK);
      got_v[k-1] = txd;
      exp_v[k-1] = (k == 1 || k > FR_BITS * 4 + 1) ? 1'b1 : fr55[(k - 2) / 4];
      if (ddata_r[6]) busy_n++;
    end
    bus_idle();
    check("frame55_txd", got_v, exp_v);
    check("frame55_busy_cycles", busy_n, FR_BITS * 4);
    check("frame55_irq", irq, 1'b0);

    // overflow with transmitter disabled
    bus_write(2'd3, 32'd0);
    for (int i = 0; i < 9; i++) bus_write(2'd0, 32'h30 + i);
    bus_read(2'd1, rdv); check("ovf_status", rdv, 32'hA8);
    bus_write(2'd1, 32'h80);
    bus_read(2'd1, rdv); check("ovf_cleared", rdv, 32'h28);
    bus_write(2'd3, 32'd1);
    wait_cycles(8 * FR_BITS * 4 + 10);
    bus_read(2'd1, rdv); check("drained_status", rdv, 32'h10);

    // back-to-back frames with a simultaneous push/pop
    bus_write(2'd2, 32'd2);
    bus_write(2'd3, 32'd3);
    check("irq_idle_empty", irq, 1'b1);
    bus_write(2'd0, 32'hA5);
    bus_write(2'd0, 32'h3C);
    bus_read(2'd1, rdv); check("pushpop_status", rdv, 32'h41);
    wait_cycles(2 * FR_BITS * 2 + 5);
    bus_read(2'd1, rdv); check("b2b_status", rdv, 32'h10);
    check("b2b_irq", irq, 1'b1);

    // reset in the middle of a frame
    bus_write(2'd3, 32'd1);
    bus_write(2'd2, 32'd4);
    bus_write(2'd0, 32'h00);
    wait_cycles(10);
    check("pre_rst_txd", txd, 1'b0);
    #2 RESET = 1'b1;
    #1 check("midrst_txd", txd, 1'b1);
    wait_cycles(3);
    #2 RESET = 1'b0;
    @(negedge CLK);
    bus_read(2'd1, rdv); check("midrst_status", rdv, 32'h10);
    bus_read(2'd2, rdv); check("midrst_bauddiv", rdv, 32'd434);

    // randomized traffic against the model
    bus_write(2'd2, 32'd1);
    bus_write(2'd3, 32'd1);
    for (int op = 0; op < 3000; op++) begin
      int r;
      r = $urandom_range(0, 99);
      if (r < 35) bus_write(2'd0, $urandom);
      else if (r < 45) bus_read(2'($urandom_range(0, 3)), rdv);
      else if (r < 50) bus_write(2'd2, 32'($urandom_range(0, 3)));
      else if (r < 58) bus_write(2'd3, 32'($urandom_range(0, 7)) | 32'($urandom_range(0, 3) != 0));
      else if (r < 62) bus_write(2'd1, $urandom);
      else if (r < 67) begin
        daddr   = 10'($urandom_range(0, 10'h3FB));
        d_rw    = 1'($urandom_range(0, 1));
        ddata_w = $urandom;
        @(negedge CLK);
        bus_idle();
      end else wait_cycles($urandom_range(1, 5));
    end
    bus_write(2'd3, 32'd3);
    wait_cycles(DEPTH * FR_BITS * 4 + 20);
    bus_read(2'd1, rdv); check("final_status_empty", rdv[6:0], 7'h10);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
